// File: rtl/phy_mgmt_pkg.sv
`default_nettype none
// ============================================================================
// phy_mgmt_pkg : shared states, PHY register map and helpers for phy_mgmt_ctrl
// Rev 1.0
// ============================================================================
package phy_mgmt_pkg;

  typedef enum logic [3:0] {
    ST_PWR_WAIT  = 4'd0,
    ST_WR_RST    = 4'd1,
    ST_RD_BMCR   = 4'd2,
    ST_CHK_RST   = 4'd3,
    ST_WR_CFG    = 4'd4,
    ST_POLL_WAIT = 4'd5,
    ST_RD_BMSR   = 4'd6,
    ST_HOST      = 4'd7,
    ST_ERR       = 4'd8
  } state_e;

  localparam logic [4:0]  REG_BMCR      = 5'd0;
  localparam logic [4:0]  REG_BMSR      = 5'd1;
  localparam int          BMCR_RST      = 15;
  localparam int          BMSR_LINK     = 2;
  localparam int          BMSR_AN_DONE  = 5;
  localparam logic [15:0] BMCR_SOFT_RST = 16'h8000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phy_mgmt_if.sv
`default_nettype none
// ============================================================================
// phy_mgmt_if : command/response bus between phy_mgmt_ctrl and the SMI engine
// Rev 1.0
// ============================================================================
interface phy_mgmt_if;
  logic        smi_oper_en;
  logic        smi_mode;
  logic [4:0]  smi_addr;
  logic [15:0] smi_wr_data;
  logic [15:0] smi_rd_data;
  logic        smi_rd_vld;

  modport master (
    output smi_oper_en, smi_mode, smi_addr, smi_wr_data,
    input  smi_rd_data, smi_rd_vld
  );

  modport slave (
    input  smi_oper_en, smi_mode, smi_addr, smi_wr_data,
    output smi_rd_data, smi_rd_vld
  );
endinterface
`default_nettype wire

// File: rtl/phy_mgmt_timer.sv
`default_nettype none
// ============================================================================
// phy_mgmt_timer : loadable saturating down-counter; done while the count is 0
// Rev 1.0
// ============================================================================
module phy_mgmt_timer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned RST_VAL = 0
) (
  input  wire             clk,
  input  wire             rst,
  input  wire             load,
  input  wire [WIDTH-1:0] load_val,
  output logic            done
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= WIDTH'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/phy_mgmt_ctrl.sv
`default_nettype none
// ============================================================================
// phy_mgmt_ctrl : PHY bring-up (soft reset, reset poll, config) and BMSR poller.
// Macro PHY_MGMT_HOST_ACCESS_EN adds a host register-access port.  Rev 1.0
// ============================================================================
module phy_mgmt_ctrl
  import phy_mgmt_pkg::*;
#(
  parameter int unsigned PWR_UP_DELAY  = 10000,
  parameter int unsigned TXN_GAP       = 1750,
  parameter int unsigned RD_TIMEOUT    = 4096,
  parameter int unsigned RST_POLL_MAX  = 16,
  parameter logic [15:0] BMCR_CFG      = 16'h1200,
  parameter int unsigned POLL_INTERVAL = 1000000
) (
  input  wire         clk,
  input  wire         rst,
  input  wire         init_req,
  phy_mgmt_if.master  smi,
  output logic        init_done,
  output logic        init_err,
  output logic        link_up,
  output logic        an_done,
  output logic [15:0] bmsr
`ifdef PHY_MGMT_HOST_ACCESS_EN
  ,
  input  wire         host_req,
  input  wire         host_wr,
  input  wire  [4:0]  host_addr,
  input  wire  [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata
`endif
);

  localparam int unsigned CNT_MAX  = max_u(max_u(PWR_UP_DELAY, TXN_GAP),
                                           max_u(RD_TIMEOUT, POLL_INTERVAL));
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned RD_CNT_W = $clog2(RST_POLL_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // Timer loads are "cycles - 1"; the power-up load is one longer so the first
  // pulse lands PWR_UP_DELAY+1 cycles after reset release.
  localparam cnt_t LD_PWR  = cnt_t'(PWR_UP_DELAY);
  localparam cnt_t LD_GAP  = cnt_t'(TXN_GAP - 1);
  localparam cnt_t LD_TO   = cnt_t'(RD_TIMEOUT - 1);
  localparam cnt_t LD_POLL = cnt_t'(POLL_INTERVAL - 1);
  localparam logic [RD_CNT_W-1:0] READS_MAX = RD_CNT_W'(RST_POLL_MAX);

  state_e              state_q, state_d;
  logic                rd_gap_q, rd_gap_d;
  logic [RD_CNT_W-1:0] reads_q, reads_d;
  logic                rst_seen_q, rst_seen_d;
  logic                oper_en_q, oper_en_d;
  logic                mode_q, mode_d;
  logic [4:0]          addr_q, addr_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                init_done_q, init_done_d;
  logic                init_err_q, init_err_d;
  logic                link_up_q, link_up_d;
  logic                an_done_q, an_done_d;
  logic [15:0]         bmsr_q, bmsr_d;

  logic                issue, issue_wr;
  logic [4:0]          issue_addr;
  logic [15:0]         issue_data;
  logic                tmr_load, tmr_done;
  cnt_t                tmr_val;

`ifdef PHY_MGMT_HOST_ACCESS_EN
  logic        host_pend_q, host_pend_d;
  logic        host_wr_q, host_wr_d;
  logic [4:0]  host_addr_q, host_addr_d;
  logic [15:0] host_wdata_q, host_wdata_d;
  logic        host_ack_q, host_ack_d;
  logic [15:0] host_rdata_q, host_rdata_d;
`endif

  phy_mgmt_timer #(
    .WIDTH   (CNT_W),
    .RST_VAL (PWR_UP_DELAY)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    rd_gap_d    = rd_gap_q;
    reads_d     = reads_q;
    rst_seen_d  = rst_seen_q;
    oper_en_d   = 1'b0;
    mode_d      = mode_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    init_done_d = init_done_q;
    init_err_d  = init_err_q;
    link_up_d   = link_up_q;
    an_done_d   = an_done_q;
    bmsr_d      = bmsr_q;
    issue       = 1'b0;
    issue_wr    = 1'b0;
    issue_addr  = REG_BMCR;
    issue_data  = '0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
`ifdef PHY_MGMT_HOST_ACCESS_EN
    host_pend_d  = host_pend_q;
    host_wr_d    = host_wr_q;
    host_addr_d  = host_addr_q;
    host_wdata_d = host_wdata_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
`endif

    if (init_req && (state_q == ST_POLL_WAIT || state_q == ST_ERR)) begin
      init_done_d = 1'b0;
      init_err_d  = 1'b0;
      link_up_d   = 1'b0;
      an_done_d   = 1'b0;
      state_d     = ST_PWR_WAIT;
      tmr_load    = 1'b1;
      tmr_val     = LD_PWR;
    end else begin
      case (state_q)
        ST_PWR_WAIT: begin
          if (tmr_done) begin
            issue      = 1'b1;
            issue_wr   = 1'b1;
            issue_data = BMCR_SOFT_RST;
            reads_d    = '0;
            state_d    = ST_WR_RST;
          end
        end
        ST_WR_RST: begin
          if (tmr_done) begin
            issue   = 1'b1;
            reads_d = reads_q + 1'b1;
            state_d = ST_RD_BMCR;
          end
        end
        ST_RD_BMCR: begin
          if (smi.smi_rd_vld) begin
            if (smi.smi_rd_data[BMCR_RST] && reads_q == READS_MAX) begin
              init_err_d = 1'b1;
              state_d    = ST_ERR;
            end else begin
              rst_seen_d = smi.smi_rd_data[BMCR_RST];
              tmr_load   = 1'b1;
              tmr_val    = LD_GAP;
              state_d    = ST_CHK_RST;
            end
          end else if (tmr_done) begin
            init_err_d = 1'b1;
            state_d    = ST_ERR;
          end
        end
        ST_CHK_RST: begin
          if (tmr_done) begin
            issue = 1'b1;
            if (rst_seen_q) begin
              reads_d = reads_q + 1'b1;
              state_d = ST_RD_BMCR;
            end else begin
              issue_wr   = 1'b1;
              issue_data = BMCR_CFG;
              state_d    = ST_WR_CFG;
            end
          end
        end
        ST_WR_CFG: begin
          if (tmr_done) begin
            init_done_d = 1'b1;
            tmr_load    = 1'b1;
            tmr_val     = LD_POLL;
            state_d     = ST_POLL_WAIT;
          end
        end
        ST_POLL_WAIT: begin
`ifdef PHY_MGMT_HOST_ACCESS_EN
          if (host_pend_q) begin
            issue       = 1'b1;
            issue_wr    = host_wr_q;
            issue_addr  = host_addr_q;
            issue_data  = host_wdata_q;
            host_pend_d = 1'b0;
            rd_gap_d    = host_wr_q;
            state_d     = ST_HOST;
          end else
`endif
          if (tmr_done) begin
            issue      = 1'b1;
            issue_addr = REG_BMSR;
            rd_gap_d   = 1'b0;
            state_d    = ST_RD_BMSR;
          end
        end
        ST_RD_BMSR: begin
          if (!rd_gap_q) begin
            if (smi.smi_rd_vld) begin
              bmsr_d    = smi.smi_rd_data;
              link_up_d = smi.smi_rd_data[BMSR_LINK];
              an_done_d = smi.smi_rd_data[BMSR_AN_DONE];
              rd_gap_d  = 1'b1;
              tmr_load  = 1'b1;
              tmr_val   = LD_GAP;
            end else if (tmr_done) begin
              link_up_d = 1'b0;
              an_done_d = 1'b0;
              tmr_load  = 1'b1;
              tmr_val   = LD_POLL;
              state_d   = ST_POLL_WAIT;
            end
          end else if (tmr_done) begin
            tmr_load = 1'b1;
            tmr_val  = LD_POLL;
            state_d  = ST_POLL_WAIT;
          end
        end
`ifdef PHY_MGMT_HOST_ACCESS_EN
        ST_HOST: begin
          // smi_mode_q still holds the direction of the host transaction.
          if (!rd_gap_q) begin
            if (smi.smi_rd_vld) begin
              host_ack_d   = 1'b1;
              host_rdata_d = smi.smi_rd_data;
              rd_gap_d     = 1'b1;
              tmr_load     = 1'b1;
              tmr_val      = LD_GAP;
            end else if (tmr_done) begin
              host_ack_d   = 1'b1;
              host_rdata_d = 16'hFFFF;
              tmr_load     = 1'b1;
              tmr_val      = LD_POLL;
              state_d      = ST_POLL_WAIT;
            end
          end else if (tmr_done) begin
            host_ack_d = mode_q;
            tmr_load   = 1'b1;
            tmr_val    = LD_POLL;
            state_d    = ST_POLL_WAIT;
          end
        end
`endif
        ST_ERR: begin
          init_err_d = 1'b1;
        end
        default: begin
          init_err_d = 1'b1;
          state_d    = ST_ERR;
        end
      endcase
    end

    if (issue) begin
      oper_en_d = 1'b1;
      mode_d    = issue_wr;
      addr_d    = issue_addr;
      if (issue_wr) begin
        wr_data_d = issue_data;
      end
      tmr_load = 1'b1;
      tmr_val  = issue_wr ? LD_GAP : LD_TO;
    end

`ifdef PHY_MGMT_HOST_ACCESS_EN
    if (host_req && !host_pend_q) begin
      host_pend_d  = 1'b1;
      host_wr_d    = host_wr;
      host_addr_d  = host_addr;
      host_wdata_d = host_wdata;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PWR_WAIT;
      rd_gap_q    <= 1'b0;
      reads_q     <= '0;
      rst_seen_q  <= 1'b0;
      oper_en_q   <= 1'b0;
      mode_q      <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
      link_up_q   <= 1'b0;
      an_done_q   <= 1'b0;
      bmsr_q      <= '0;
`ifdef PHY_MGMT_HOST_ACCESS_EN
      host_pend_q  <= 1'b0;
      host_wr_q    <= 1'b0;
      host_addr_q  <= '0;
      host_wdata_q <= '0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_gap_q    <= rd_gap_d;
      reads_q     <= reads_d;
      rst_seen_q  <= rst_seen_d;
      oper_en_q   <= oper_en_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      init_done_q <= init_done_d;
      init_err_q  <= init_err_d;
      link_up_q   <= link_up_d;
      an_done_q   <= an_done_d;
      bmsr_q      <= bmsr_d;
`ifdef PHY_MGMT_HOST_ACCESS_EN
      host_pend_q  <= host_pend_d;
      host_wr_q    <= host_wr_d;
      host_addr_q  <= host_addr_d;
      host_wdata_q <= host_wdata_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
`endif
    end
  end

  assign smi.smi_oper_en = oper_en_q;
  assign smi.smi_mode    = mode_q;
  assign smi.smi_addr    = addr_q;
  assign smi.smi_wr_data = wr_data_q;
  assign init_done       = init_done_q;
  assign init_err        = init_err_q;
  assign link_up         = link_up_q;
  assign an_done         = an_done_q;
  assign bmsr            = bmsr_q;
`ifdef PHY_MGMT_HOST_ACCESS_EN
  assign host_ack        = host_ack_q;
  assign host_rdata      = host_rdata_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_phy_mgmt_ctrl.sv
`default_nettype none
// ============================================================================
// tb_phy_mgmt_ctrl : directed bring-up, polling, timeout and restart sequences
// Rev 1.0
// ============================================================================
module tb_phy_mgmt_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_req = 1'b0;
  logic        init_done, init_err, link_up, an_done;
  logic [15:0] bmsr;

  int tests = 0;
  int fails = 0;
  int dbl_cnt = 0;
  logic prev_en = 1'b0;

  phy_mgmt_if smi_if ();

  phy_mgmt_ctrl #(
    .PWR_UP_DELAY  (20),
    .TXN_GAP       (40),
    .RD_TIMEOUT    (100),
    .RST_POLL_MAX  (4),
    .BMCR_CFG      (16'h1200),
    .POLL_INTERVAL (200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_req  (init_req),
    .smi       (smi_if),
    .init_done (init_done),
    .init_err  (init_err),
    .link_up   (link_up),
    .an_done   (an_done),
    .bmsr      (bmsr)
  );

  always #5 clk = ~clk;

  // Any strobe lasting two consecutive cycles is recorded here.
  always @(negedge clk) begin
    prev_en <= smi_if.smi_oper_en;
    if (smi_if.smi_oper_en && prev_en) dbl_cnt <= dbl_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(input int maxc, output bit got, output int n);
    got = 1'b0;
    n   = 0;
    while (!got && n < maxc) begin
      @(negedge clk);
      n++;
      if (smi_if.smi_oper_en === 1'b1) got = 1'b1;
    end
  endtask

  task automatic expect_cmd(input string tag, input int exp_n, input bit wr,
                            input logic [4:0] addr, input logic [15:0] data);
    bit got;
    int n;
    wait_pulse(1000, got, n);
    check({tag, "_seen"}, 32'(got), 32'd1);
    check({tag, "_gap"}, 32'(n), 32'(exp_n));
    check({tag, "_mode"}, 32'(smi_if.smi_mode), 32'(wr));
    check({tag, "_addr"}, 32'(smi_if.smi_addr), 32'(addr));
    if (wr) check({tag, "_data"}, 32'(smi_if.smi_wr_data), 32'(data));
  endtask

  task automatic respond(input logic [15:0] val, input int lat);
    repeat (lat) @(negedge clk);
    smi_if.smi_rd_data = val;
    smi_if.smi_rd_vld  = 1'b1;
    @(negedge clk);
    smi_if.smi_rd_vld  = 1'b0;
  endtask

  initial begin
    bit got;
    int n;
    smi_if.smi_rd_vld  = 1'b0;
    smi_if.smi_rd_data = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_oper_en", 32'(smi_if.smi_oper_en), 32'd0);
    check("rst_mode", 32'(smi_if.smi_mode), 32'd0);
    check("rst_addr", 32'(smi_if.smi_addr), 32'd0);
    check("rst_wr_data", 32'(smi_if.smi_wr_data), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_init_err", 32'(init_err), 32'd0);
    check("rst_link_up", 32'(link_up), 32'd0);
    check("rst_an_done", 32'(an_done), 32'd0);
    check("rst_bmsr", 32'(bmsr), 32'd0);
    rst = 1'b0;

    // Bring-up, reset clears on the first read; init_req in WR_RST is ignored
    expect_cmd("wr_rst_a", 21, 1'b1, 5'd0, 16'h8000);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    expect_cmd("rd_bmcr_a", 39, 1'b0, 5'd0, 16'h0);
    check("done_before_cfg", 32'(init_done), 32'd0);
    respond(16'h0000, 5);
    expect_cmd("wr_cfg_a", 40, 1'b1, 5'd0, 16'h1200);
    expect_cmd("poll_1", 240, 1'b0, 5'd1, 16'h0);
    check("init_done_a", 32'(init_done), 32'd1);
    check("link_pre", 32'(link_up), 32'd0);

    // Good BMSR read
    respond(16'h0024, 8);
    check("link_1", 32'(link_up), 32'd1);
    check("an_1", 32'(an_done), 32'd1);
    check("bmsr_1", 32'(bmsr), 32'h0024);

    // Stray rd_vld during the gap must be ignored
    respond(16'h0000, 3);
    check("link_stray", 32'(link_up), 32'd1);
    check("bmsr_stray", 32'(bmsr), 32'h0024);
    expect_cmd("poll_2", 236, 1'b0, 5'd1, 16'h0);

    // Poll read with no response
    n = 0;
    while (link_up === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("to_link_n", 32'(n), 32'd100);
    check("to_an", 32'(an_done), 32'd0);
    check("to_bmsr_kept", 32'(bmsr), 32'h0024);
    expect_cmd("poll_3", 200, 1'b0, 5'd1, 16'h0);

    // rd_vld in the same cycle as the timeout wins
    respond(16'h0004, 99);
    check("edge_link", 32'(link_up), 32'd1);
    check("edge_an", 32'(an_done), 32'd0);
    check("edge_bmsr", 32'(bmsr), 32'h0004);
    expect_cmd("poll_4", 240, 1'b0, 5'd1, 16'h0);

    // init_req accepted in POLL_WAIT
    respond(16'h0024, 5);
    repeat (45) @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    check("req_init_done", 32'(init_done), 32'd0);
    check("req_link", 32'(link_up), 32'd0);
    check("req_an", 32'(an_done), 32'd0);
    expect_cmd("wr_rst_b", 21, 1'b1, 5'd0, 16'h8000);

    // BMCR[15] stays set for three reads
    for (int i = 0; i < 4; i++) begin
      expect_cmd("rd_bmcr_retry", 40, 1'b0, 5'd0, 16'h0);
      respond((i < 3) ? 16'h8000 : 16'h0000, 5);
    end
    expect_cmd("wr_cfg_b", 40, 1'b1, 5'd0, 16'h1200);
    expect_cmd("poll_b", 240, 1'b0, 5'd1, 16'h0);

    // rst in the middle of a read
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_oper_en", 32'(smi_if.smi_oper_en), 32'd0);
    check("mid_rst_addr", 32'(smi_if.smi_addr), 32'd0);
    check("mid_rst_wr_data", 32'(smi_if.smi_wr_data), 32'd0);
    check("mid_rst_init_done", 32'(init_done), 32'd0);
    check("mid_rst_bmsr", 32'(bmsr), 32'd0);
    rst = 1'b0;
    expect_cmd("wr_rst_c", 21, 1'b1, 5'd0, 16'h8000);

    // BMCR[15] never clears
    for (int i = 0; i < 4; i++) begin
      expect_cmd("rd_bmcr_stuck", 40, 1'b0, 5'd0, 16'h0);
      respond(16'h8000, 5);
    end
    check("stuck_init_err", 32'(init_err), 32'd1);
    check("stuck_init_done", 32'(init_done), 32'd0);
    wait_pulse(500, got, n);
    check("err_quiet", 32'(got), 32'd0);

    // init_req leaves ERR
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    check("err_cleared", 32'(init_err), 32'd0);
    expect_cmd("wr_rst_d", 21, 1'b1, 5'd0, 16'h8000);

    check("single_cycle_strobe", 32'(dbl_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
